sd_read: RTL and testbench

SD_READ -- requirements
Module: sd_read

---
 rtl/sd_read.sv | 209 ++++++++++++++++++++
 tb/tb_sd_read.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_read.sv
// SPI-mode SD card single-block reader: issues CMD17, waits for an R1 of zero,
// hunts the start token, then streams DATA_NUM 16-bit words followed by the CRC.
module sd_read #(
    parameter logic [11:0] DATA_NUM    = 12'd256,
    parameter logic [7:0]  DATA_TOKEN  = 8'hFE,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
    input  logic        sys_clk_shift,
    input  logic        sys_rst_n,
    input  logic        miso,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic        cs_n,
    output logic        mosi,
    output logic        rd_busy,
    output logic        rd_data_en,
    output logic [15:0] rd_data
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEND_CMD17 = 3'd1,
        CMD17_ACK  = 3'd2,
        RD_TOKEN   = 3'd3,
        RD_DATA    = 3'd4,
        RD_CRC     = 3'd5,
        RD_END     = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_cs_n;
    logic [31:0] r_addr;
    logic [5:0]  r_cmd_cnt;
    logic [7:0]  r_ack_cnt;
    logic        r_r1_act;
    logic [2:0]  r_r1_cnt;
    // Shift registers keep one bit fewer than their width: the newest bit is miso itself.
    logic [6:0]  r_r1;
    logic [6:0]  r_token;
    logic [14:0] r_acc;
    logic [3:0]  r_bit_cnt;
    logic [11:0] r_word_cnt;
    logic [3:0]  r_crc_cnt;
    logic [2:0]  r_end_cnt;
    logic        r_rd_data_en;
    logic [15:0] r_rd_data;

    logic [47:0] w_cmd;
    logic [7:0]  w_r1_next;
    logic [7:0]  w_token_next;
    logic [15:0] w_word;

    assign w_cmd        = {8'h51, r_addr, 8'hFF};
    assign w_r1_next    = {r_r1, miso};
    assign w_token_next = {r_token, miso};
    assign w_word       = {r_acc, miso};

    assign cs_n       = r_cs_n;
    assign mosi       = (r_state == SEND_CMD17) ? w_cmd[6'd47 - r_cmd_cnt] : 1'b1;
    assign rd_busy    = (r_state != IDLE);
    assign rd_data_en = r_rd_data_en;
    assign rd_data    = r_rd_data;

    // State register
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (rd_en) w_next = SEND_CMD17;
                else       w_next = IDLE;
            end
            SEND_CMD17: begin
                if (r_cmd_cnt == 6'd47) w_next = CMD17_ACK;
                else                    w_next = SEND_CMD17;
            end
            CMD17_ACK: begin
                if (r_r1_act) begin
                    if (r_r1_cnt == 3'd7) begin
                        if (w_r1_next == 8'h00) w_next = RD_TOKEN;
                        else                    w_next = SEND_CMD17;
                    end else begin
                        w_next = CMD17_ACK;
                    end
                end else if (!miso) begin
                    w_next = CMD17_ACK;
                end else if (r_ack_cnt == ACK_TIMEOUT - 8'd1) begin
                    w_next = SEND_CMD17;
                end else begin
                    w_next = CMD17_ACK;
                end
            end
            RD_TOKEN: begin
                if (w_token_next == DATA_TOKEN) w_next = RD_DATA;
                else                            w_next = RD_TOKEN;
            end
            RD_DATA: begin
                if (r_bit_cnt == 4'hF && r_word_cnt == DATA_NUM - 12'd1) w_next = RD_CRC;
                else                                                     w_next = RD_DATA;
            end
            RD_CRC: begin
                if (r_crc_cnt == 4'hF) w_next = RD_END;
                else                   w_next = RD_CRC;
            end
            RD_END: begin
                if (r_end_cnt == 3'd7) w_next = IDLE;
                else                   w_next = RD_END;
            end
            default: w_next = IDLE;
        endcase
    end

    // Address latch; chip select is released exactly when the FSM heads back to IDLE
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_addr <= 32'h0000_0000;
            r_cs_n <= 1'b1;
        end else begin
            if (r_state == IDLE && rd_en) r_addr <= rd_addr;
            r_cs_n <= (w_next == IDLE);
        end
    end

    // Command bit counter and token hunter
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cmd_cnt <= 6'd0;
            r_token   <= 7'h7F;
        end else begin
            r_cmd_cnt <= (r_state == SEND_CMD17 && w_next == SEND_CMD17) ? r_cmd_cnt + 6'd1 : 6'd0;
            r_token   <= (r_state == RD_TOKEN && w_next == RD_TOKEN) ? w_token_next[6:0] : 7'h7F;
        end
    end

    // R1 wait timer and capture
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ack_cnt <= 8'd0;
            r_r1_act  <= 1'b0;
            r_r1_cnt  <= 3'd0;
            r_r1      <= 7'd0;
        end else if (r_state == CMD17_ACK && w_next == CMD17_ACK) begin
            if (r_r1_act) begin
                r_r1     <= w_r1_next[6:0];
                r_r1_cnt <= r_r1_cnt + 3'd1;
            end else if (!miso) begin
                r_r1_act <= 1'b1;
                r_r1     <= w_r1_next[6:0];
                r_r1_cnt <= 3'd1;
            end else begin
                r_ack_cnt <= r_ack_cnt + 8'd1;
            end
        end else begin
            r_ack_cnt <= 8'd0;
            r_r1_act  <= 1'b0;
            r_r1_cnt  <= 3'd0;
            r_r1      <= 7'd0;
        end
    end

    // Data word assembly counters
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_acc      <= 15'd0;
            r_bit_cnt  <= 4'd0;
            r_word_cnt <= 12'd0;
        end else if (r_state == RD_DATA && w_next == RD_DATA) begin
            r_acc     <= w_word[14:0];
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'hF) r_word_cnt <= r_word_cnt + 12'd1;
        end else begin
            r_acc      <= 15'd0;
            r_bit_cnt  <= 4'd0;
            r_word_cnt <= 12'd0;
        end
    end

    // Word output and one-cycle strobe
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_data_en <= 1'b0;
            r_rd_data    <= 16'h0000;
        end else if (r_state == RD_DATA && r_bit_cnt == 4'hF) begin
            r_rd_data_en <= 1'b1;
            r_rd_data    <= w_word;
        end else begin
            r_rd_data_en <= 1'b0;
        end
    end

    // CRC skip and chip-select tail counters
    always_ff @(posedge sys_clk_shift or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_crc_cnt <= 4'd0;
            r_end_cnt <= 3'd0;
        end else begin
            r_crc_cnt <= (r_state == RD_CRC && w_next == RD_CRC) ? r_crc_cnt + 4'd1 : 4'd0;
            r_end_cnt <= (r_state == RD_END && w_next == RD_END) ? r_end_cnt + 3'd1 : 3'd0;
        end
    end

endmodule

// File: tb/tb_sd_read.sv
// Bench for sd_read: a behavioural SD card answers each CMD17 from a scripted
// response kind, expected words go to a scoreboard that a separate monitor drains.
module tb_sd_read;
    localparam int DATA_NUM    = 256;
    localparam int ACK_TIMEOUT = 255;

    logic        sys_clk_shift = 1'b0;
    logic        sys_rst_n     = 1'b0;
    logic        miso          = 1'b1;
    logic        rd_en         = 1'b0;
    logic [31:0] rd_addr       = 32'h0;
    logic        cs_n;
    logic        mosi;
    logic        rd_busy;
    logic        rd_data_en;
    logic [15:0] rd_data;

    sd_read dut (
        .sys_clk_shift (sys_clk_shift),
        .sys_rst_n     (sys_rst_n),
        .miso          (miso),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .cs_n          (cs_n),
        .mosi          (mosi),
        .rd_busy       (rd_busy),
        .rd_data_en    (rd_data_en),
        .rd_data       (rd_data)
    );

    always #5 sys_clk_shift = ~sys_clk_shift;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [47:0] exp_cmd_q[$];
    int          kind_q[$];     // 0: R1=00 + data, 1: R1=04, 2: silence
    bit          resp_q[$];
    int          strobe_cnt = 0;
    int          cyc = 0;
    int          last_strobe_cyc = 0;
    logic [15:0] exp_hold = 16'h0000;
    int          ff_bits = 0;
    int          word_pat = 0;  // 0: incrementing, 1: A55A then random, 2: random

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    initial begin
        logic        prev_cs;
        logic [15:0] e;
        prev_cs = 1'b1;
        forever begin
            @(negedge sys_clk_shift);
            cyc++;
            if (rd_data_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_unexpected: rd_data %0h, no word expected", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e);
                    exp_hold = e;
                end
                strobe_cnt++;
                if (strobe_cnt == DATA_NUM) last_strobe_cyc = cyc;
            end else begin
                chk("rd_data_hold", rd_data, exp_hold);
            end
            if (prev_cs === 1'b0 && cs_n === 1'b1 && sys_rst_n && strobe_cnt == DATA_NUM) begin
                chk("cs_n_rise_delay", cyc - last_strobe_cyc, 24);
                chk("busy_at_cs_rise", rd_busy, 0);
            end
            prev_cs = cs_n;
        end
    end

    // Behavioural card
    initial begin
        logic [47:0] sr;
        logic [7:0]  byte_v;
        logic [15:0] w;
        int          ncol, kind, sil_end, ccyc;
        bit          collecting, last_sil;
        collecting = 0; last_sil = 0; ncol = 0; sil_end = 0; ccyc = 0; sr = 48'h0;
        forever begin
            @(negedge sys_clk_shift);
            ccyc++;
            if (!sys_rst_n) begin
                collecting = 0;
                last_sil   = 0;
                resp_q.delete();
                miso = 1'b1;
            end else begin
                if (collecting) begin
                    sr = {sr[46:0], mosi};
                    ncol++;
                    if (ncol == 48) begin
                        collecting = 0;
                        if (exp_cmd_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL cmd_unexpected: got %012h, none expected", sr);
                        end else begin
                            chk("cmd17_frame", sr, exp_cmd_q.pop_front());
                        end
                        kind = (kind_q.size() > 0) ? kind_q.pop_front() : 2;
                        resp_q.delete();
                        if (kind == 2) begin
                            repeat (300) resp_q.push_back(1'b1);
                            last_sil = 1;
                            sil_end  = ccyc;
                        end else begin
                            repeat ($urandom_range(1, 16)) resp_q.push_back(1'b1);
                            byte_v = (kind == 1) ? 8'h04 : 8'h00;
                            for (int b = 7; b >= 0; b--) resp_q.push_back(byte_v[b]);
                            if (kind == 0) begin
                                repeat (ff_bits) resp_q.push_back(1'b1);
                                byte_v = 8'hFE;
                                for (int b = 7; b >= 0; b--) resp_q.push_back(byte_v[b]);
                                for (int i = 0; i < DATA_NUM; i++) begin
                                    if (word_pat == 0)               w = 16'(i);
                                    else if (word_pat == 1 && i == 0) w = 16'hA55A;
                                    else                             w = 16'($urandom);
                                    exp_q.push_back(w);
                                    for (int b = 15; b >= 0; b--) resp_q.push_back(w[b]);
                                end
                                repeat (16) resp_q.push_back(1'($urandom));
                            end
                        end
                    end
                end else if (cs_n === 1'b0 && mosi === 1'b0) begin
                    collecting = 1;
                    sr   = {47'h0, mosi};
                    ncol = 1;
                    if (last_sil) begin
                        chk("ack_timeout_gap", ccyc - sil_end - 1, ACK_TIMEOUT);
                        last_sil = 0;
                    end
                end
                miso = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b1;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, cs_n, 1);
        chk({tag, "_mosi"}, mosi, 1);
        chk({tag, "_rd_busy"}, rd_busy, 0);
        chk({tag, "_rd_data_en"}, rd_data_en, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int n_cmds, input int pulse_at, input int reset_at);
        int t;
        bit pulsed, done;
        for (int i = 0; i < n_cmds; i++) exp_cmd_q.push_back({8'h51, addr, 8'hFF});
        strobe_cnt = 0;
        pulsed = 0;
        done   = 0;
        @(negedge sys_clk_shift);
        rd_en = 1'b1;
        rd_addr = addr;
        @(negedge sys_clk_shift);
        rd_en = 1'b0;
        rd_addr = $urandom;
        chk("busy_after_rd_en", rd_busy, 1);
        chk("cs_n_after_rd_en", cs_n, 0);
        for (t = 0; t < 20000 && !done; t++) begin
            @(negedge sys_clk_shift);
            rd_en = 1'b0;
            if (pulse_at >= 0 && !pulsed && strobe_cnt >= pulse_at) begin
                rd_en   = 1'b1;
                rd_addr = ~addr;
                pulsed  = 1;
            end
            if (reset_at >= 0 && strobe_cnt >= reset_at) begin
                #2;
                sys_rst_n = 1'b0;
                exp_hold  = 16'h0000;
                exp_q.delete();
                kind_q.delete();
                exp_cmd_q.delete();
                #1;
                check_reset_outputs("mid_read_reset");
                repeat (3) @(negedge sys_clk_shift);
                sys_rst_n = 1'b1;
                repeat (4) @(negedge sys_clk_shift);
                check_reset_outputs("after_release");
                return;
            end
            if (!rd_busy) done = 1;
        end
        rd_en = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL read_timeout: rd_busy %0b after %0d cycles, want 0", rd_busy, t);
        end
        chk("strobe_count", strobe_cnt, DATA_NUM);
        chk("words_left", exp_q.size(), 0);
        chk("cmds_left", exp_cmd_q.size(), 0);
        repeat (2) @(negedge sys_clk_shift);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk_shift);
        check_reset_outputs("in_reset");
        sys_rst_n = 1'b1;
        @(negedge sys_clk_shift);
        check_reset_outputs("post_release");

        // Basic read, incrementing words
        ff_bits = 8 * $urandom_range(0, 4); word_pat = 0;
        kind_q.push_back(0);
        do_read(32'h0000_1234, 1, -1, -1);

        // Bad R1 once, then good
        word_pat = 2;
        kind_q.push_back(1); kind_q.push_back(0);
        do_read($urandom, 2, -1, -1);

        // No R1 at all, then good
        kind_q.push_back(2); kind_q.push_back(0);
        do_read($urandom, 2, -1, -1);

        // Long token wait, first word A55A
        ff_bits = 20; word_pat = 1;
        kind_q.push_back(0);
        do_read($urandom, 1, -1, -1);

        // rd_en pulse mid-read
        ff_bits = $urandom_range(0, 40); word_pat = 2;
        kind_q.push_back(0);
        do_read($urandom, 1, 50, -1);

        // Reset at word 100, then a full read
        kind_q.push_back(0);
        do_read($urandom, 1, -1, 100);
        kind_q.push_back(0);
        do_read($urandom, 1, -1, -1);

        for (int k = 0; k < 2; k++) begin
            ff_bits = $urandom_range(0, 64);
            kind_q.push_back(0);
            do_read($urandom, 1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
